// File: rtl/hack_fetch_ctrl.sv
// rtl/hack_fetch_ctrl.sv - Hack CPU fetch/execute sequencer with halt/step, ROM timeout and retire counter
module hack_fetch_ctrl #(
   parameter int ROM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cpu_reset,
   input  logic [15:0] pc_out,
   output logic        pc_load,
   output logic        pc_inc,
   output logic        pc_reset,
   output logic        rom_req,
   output logic [15:0] rom_addr,
   input  logic        rom_ack,
   input  logic [15:0] rom_data,
   output logic [15:0] instr,
   output logic        instr_valid,
   input  logic        exec_done,
   input  logic        zr,
   input  logic        ng,
   input  logic        halt_req,
   input  logic        step,
   output logic        halted,
   output logic        fetch_err,
   output logic [15:0] instr_count
);

   localparam logic [2:0] S_BOOT   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_UPDATE = 3'd3;
   localparam logic [2:0] S_HALT   = 3'd4;
   localparam logic [2:0] S_ERROR  = 3'd5;

   localparam logic [7:0] TO_LAST = 8'(ROM_TIMEOUT - 1);

   logic [2:0] state;
   logic [2:0] state_nx;
   logic       live;
   logic       jump;
   logic       jump_c;
   logic       step_run;
   logic [7:0] tcnt;

   // live keeps BOOT's pc_reset strobe quiet while reset_n is held low
   assign jump_c = instr[15] & ((instr[2] & ng) | (instr[1] & zr) | (instr[0] & ~ng & ~zr));

   always_comb begin
      state_nx = state;
      case (state)
         S_BOOT:   if (live) state_nx = S_FETCH;
         S_FETCH: begin
            if (rom_ack)
               state_nx = S_EXEC;
            else if (tcnt == TO_LAST)
               state_nx = S_ERROR;
         end
         S_EXEC:   if (exec_done) state_nx = S_UPDATE;
         S_UPDATE: state_nx = (halt_req || step_run) ? S_HALT : S_FETCH;
         S_HALT:   if (!halt_req || step) state_nx = S_FETCH;
         S_ERROR:  state_nx = S_ERROR;
         default:  state_nx = S_BOOT;
      endcase
      if (cpu_reset)
         state_nx = S_BOOT;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_BOOT;
         live        <= 1'b0;
         tcnt        <= 8'd0;
         instr       <= 16'd0;
         instr_valid <= 1'b0;
         jump        <= 1'b0;
         step_run    <= 1'b0;
         fetch_err   <= 1'b0;
         instr_count <= 16'd0;
      end else begin
         state       <= state_nx;
         live        <= 1'b1;
         instr_valid <= 1'b0;
         tcnt        <= (state == S_FETCH) ? tcnt + 8'd1 : 8'd0;
         if (cpu_reset) begin
            instr       <= 16'd0;
            jump        <= 1'b0;
            step_run    <= 1'b0;
            fetch_err   <= 1'b0;
            instr_count <= 16'd0;
         end else begin
            case (state)
               S_FETCH: begin
                  if (rom_ack) begin
                     instr       <= rom_data;
                     instr_valid <= 1'b1;
                  end else if (tcnt == TO_LAST) begin
                     fetch_err <= 1'b1;
                  end
               end
               S_EXEC: if (exec_done) jump <= jump_c;
               S_UPDATE: begin
                  step_run <= 1'b0;
                  if (instr_count != 16'hFFFF)
                     instr_count <= instr_count + 16'd1;
               end
               S_HALT: if (halt_req && step) step_run <= 1'b1;
               default: ;
            endcase
         end
      end
   end

   // a cpu_reset landing on UPDATE suppresses the PC strobe of that cycle
   assign rom_req  = (state == S_FETCH);
   assign rom_addr = rom_req ? pc_out : 16'd0;
   assign pc_reset = (state == S_BOOT) & live;
   assign pc_load  = (state == S_UPDATE) & jump & ~cpu_reset;
   assign pc_inc   = (state == S_UPDATE) & ~jump & ~cpu_reset;
   assign halted   = (state == S_HALT);

endmodule

// File: tb/tb_hack_fetch_ctrl.sv
// tb/tb_hack_fetch_ctrl.sv - directed scoreboard bench for hack_fetch_ctrl
module tb_hack_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset_n, cpu_reset;
   logic [15:0] pc_out;
   logic        pc_load, pc_inc, pc_reset, rom_req;
   logic [15:0] rom_addr;
   logic        rom_ack;
   logic [15:0] rom_data;
   logic [15:0] instr;
   logic        instr_valid, exec_done, zr, ng, halt_req, step;
   logic        halted, fetch_err;
   logic [15:0] instr_count;

   typedef struct {
      logic [15:0] instr;
      logic        jump;
   } sb_t;

   sb_t         sb_q[$];
   int          tests = 0;
   int          fails = 0;
   logic [15:0] exp_count = 16'd0;
   logic [15:0] pc = 16'd0;
   localparam logic [15:0] AREG = 16'h0040;

   hack_fetch_ctrl #(.ROM_TIMEOUT(15)) dut (
      .clk(clk), .reset_n(reset_n), .cpu_reset(cpu_reset), .pc_out(pc_out),
      .pc_load(pc_load), .pc_inc(pc_inc), .pc_reset(pc_reset),
      .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
      .instr(instr), .instr_valid(instr_valid), .exec_done(exec_done),
      .zr(zr), .ng(ng), .halt_req(halt_req), .step(step),
      .halted(halted), .fetch_err(fetch_err), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   // external PC register, loaded from a fixed A value
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)      pc <= 16'd0;
      else if (pc_reset) pc <= 16'd0;
      else if (pc_load)  pc <= AREG;
      else if (pc_inc)   pc <= pc + 16'd1;
   end
   assign pc_out = pc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n === 1'b1)
         chk("strobe exclusivity", {31'd0, $onehot0({pc_load, pc_inc, pc_reset})}, 1);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic run_instr(input logic [15:0] w, input logic z, input logic n, input int ack_dly,
                            input int done_dly, input logic exp_jump, input logic halt_mid);
      sb_t e;
      for (int i = 0; i < 50 && rom_req !== 1'b1; i++) tick();
      chk("fetch rom_req", rom_req, 1);
      chk("fetch rom_addr", rom_addr, pc_out);
      chk("fetch halted", halted, 0);
      for (int i = 0; i < ack_dly; i++) begin
         tick();
         chk("fetch wait rom_req", rom_req, 1);
      end
      rom_ack = 1'b1;
      rom_data = w;
      e.instr = w;
      e.jump = exp_jump;
      sb_q.push_back(e);
      tick();
      rom_ack = 1'b0;
      rom_data = 16'hDEAD;
      chk("exec instr", instr, w);
      chk("exec instr_valid", instr_valid, 1);
      chk("exec rom_req", rom_req, 0);
      zr = z;
      ng = n;
      if (halt_mid) halt_req = 1'b1;
      for (int i = 0; i < done_dly; i++) begin
         tick();
         chk("exec instr_valid low", instr_valid, 0);
         chk("exec no strobe", {pc_load, pc_inc}, 0);
      end
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      chk("scoreboard nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk("update pc_load", pc_load, e.jump);
         chk("update pc_inc", pc_inc, !e.jump);
         chk("update instr", instr, e.instr);
      end
      if (exp_count != 16'hFFFF) exp_count++;
      tick();
      chk("instr_count", instr_count, exp_count);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset_n = 1'b0; cpu_reset = 1'b0; rom_ack = 1'b0; rom_data = 16'd0;
      exec_done = 1'b0; zr = 1'b0; ng = 1'b0; halt_req = 1'b0; step = 1'b0;
      repeat (3) begin
         tick();
         chk("reset outputs", {pc_load, pc_inc, pc_reset, rom_req, instr_valid, halted, fetch_err}, 0);
         chk("reset rom_addr", rom_addr, 0);
         chk("reset instr", instr, 0);
         chk("reset instr_count", instr_count, 0);
      end
      reset_n = 1'b1;
      tick();
      chk("boot pc_reset", pc_reset, 1);
      chk("boot rom_req", rom_req, 0);
      tick();
      chk("boot fetch rom_req", rom_req, 1);
      chk("boot pc_reset once", pc_reset, 0);
      chk("boot rom_addr", rom_addr, 16'd0);
      run_instr(16'h0005, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

      // jump decode
      run_instr(16'hE302, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
      run_instr(16'hE302, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0);
      run_instr(16'h0007, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
      run_instr(16'hEA87, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
      run_instr(16'hE304, 1'b0, 1'b1, 0, 2, 1'b1, 1'b0);
      run_instr(16'hE301, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
      run_instr(16'hE300, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);

      // ROM wait, then ack on the last permitted cycle
      run_instr(16'h0011, 1'b0, 1'b0, 4, 0, 1'b0, 1'b0);
      run_instr(16'h0012, 1'b0, 1'b0, 14, 0, 1'b0, 1'b0);

      // timeout
      n = 0;
      while (rom_req === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      chk("timeout fetch cycles", n, 15);
      chk("timeout fetch_err", fetch_err, 1);
      chk("timeout rom_req", rom_req, 0);
      rom_ack = 1'b1;
      repeat (5) tick();
      rom_ack = 1'b0;
      chk("error sticky", fetch_err, 1);
      chk("error strobes", {pc_load, pc_inc, pc_reset, rom_req}, 0);
      cpu_reset = 1'b1;
      tick();
      cpu_reset = 1'b0;
      chk("error exit pc_reset", pc_reset, 1);
      chk("error exit fetch_err", fetch_err, 0);
      chk("error exit instr_count", instr_count, 0);
      exp_count = 16'd0;
      run_instr(16'h0021, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

      // halt at boundary, single step, resume
      run_instr(16'hEA87, 1'b0, 1'b0, 0, 1, 1'b1, 1'b1);
      chk("halt halted", halted, 1);
      repeat (3) tick();
      chk("halt idle", {halted, rom_req, pc_load, pc_inc, pc_reset}, 5'b10000);
      chk("halt count held", instr_count, exp_count);
      step = 1'b1;
      tick();
      step = 1'b0;
      chk("step leaves halt", halted, 0);
      run_instr(16'h0031, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0);
      chk("step rehalt", halted, 1);
      tick();
      chk("step stays halted", halted, 1);
      halt_req = 1'b0;
      tick();
      chk("resume halted", halted, 0);
      run_instr(16'h0032, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
      chk("free run halted", halted, 0);
      step = 1'b1;
      run_instr(16'h0033, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
      step = 1'b0;
      chk("step outside halt ignored", halted, 0);

      // cpu_reset coincident with exec_done on a pending jump
      for (int i = 0; i < 50 && rom_req !== 1'b1; i++) tick();
      rom_ack = 1'b1;
      rom_data = 16'hEA87;
      tick();
      rom_ack = 1'b0;
      exec_done = 1'b1;
      cpu_reset = 1'b1;
      tick();
      exec_done = 1'b0;
      cpu_reset = 1'b0;
      chk("cpu_reset no load/inc", {pc_load, pc_inc}, 0);
      chk("cpu_reset pc_reset", pc_reset, 1);
      chk("cpu_reset instr_count", instr_count, 0);
      chk("cpu_reset instr", instr, 0);
      chk("cpu_reset instr_valid", instr_valid, 0);
      exp_count = 16'd0;
      run_instr(16'h0041, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

      // saturation
      for (int i = 0; i < 50 && rom_req !== 1'b1; i++) tick();
      dut.instr_count = 16'hFFFE;
      exp_count = 16'hFFFE;
      run_instr(16'h0051, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
      run_instr(16'h0052, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
      run_instr(16'hEA87, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
      chk("saturated count", instr_count, 16'hFFFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
